capture_ctrl: RTL

// - Capture front end of the internal logic analyzer; sits directly upstream of the memory read-out stage.
// - Streams probe samples into the circular sample memory. Write address wraps modulo MEMORY_SIZE.
// - Waits for a masked trigger, then captures POST_TRIG more samples and freezes waddr on the oldest sample.
// - Then pulses read_enable for exactly MEMORY_SIZE cycles to drain memory through the read-out stage.

---
 rtl/capture_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/capture_ctrl.sv
// Capture front end of the logic analyzer: streams probe samples into a circular
// memory, waits for a masked trigger, finishes the post-trigger window, then drains.
module capture_ctrl #(
   parameter int DATA_WIDTH  = 8,
   parameter int ADDR_WIDTH  = 4,
   parameter int MEMORY_SIZE = 16,
   parameter int POST_TRIG   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   input  logic [DATA_WIDTH-1:0] sample_in,
   input  logic [DATA_WIDTH-1:0] trigger_value,
   input  logic [DATA_WIDTH-1:0] trigger_mask,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] waddr,
   output logic [DATA_WIDTH-1:0] wdata,
   output logic                  read_enable,
   output logic                  triggered,
   output logic [ADDR_WIDTH-1:0] trig_addr,
   output logic                  done
);

   localparam int CW = ADDR_WIDTH + 1;
   localparam bit PRE_EMPTY = (POST_TRIG == MEMORY_SIZE);
   localparam logic [CW-1:0] PRE_LAST  = CW'(MEMORY_SIZE - POST_TRIG - 1);
   localparam logic [CW-1:0] POST_LAST = CW'(POST_TRIG - 1);
   localparam logic [CW-1:0] RD_LAST   = CW'(MEMORY_SIZE - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRETRIG,
      S_WAIT_TRIG,
      S_POST,
      S_READOUT,
      S_DONE
   } state_t;

   state_t                  state, state_nxt;
   logic [CW-1:0]           cnt, cnt_nxt;
   logic [ADDR_WIDTH-1:0]   waddr_nxt, trig_addr_nxt;
   logic                    triggered_nxt;
   logic                    match;

   assign match = ((sample_in ^ trigger_value) & trigger_mask) == '0;
   assign wdata = sample_in;

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      trig_addr_nxt = trig_addr;
      triggered_nxt = triggered;
      wr_en         = (state == S_PRETRIG) || (state == S_WAIT_TRIG) || (state == S_POST);
      waddr_nxt     = wr_en ? waddr + 1'b1 : waddr;

      // abort outranks start, trigger and count completion, and pins waddr where it is
      if (abort) begin
         state_nxt     = S_IDLE;
         triggered_nxt = 1'b0;
         waddr_nxt     = waddr;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_nxt     = PRE_EMPTY ? S_WAIT_TRIG : S_PRETRIG;
                  waddr_nxt     = '0;
                  cnt_nxt       = '0;
                  triggered_nxt = 1'b0;
               end
            end
            S_PRETRIG: begin
               cnt_nxt = cnt + 1'b1;
               if (cnt == PRE_LAST) state_nxt = S_WAIT_TRIG;
            end
            S_WAIT_TRIG: begin
               if (match) begin
                  triggered_nxt = 1'b1;
                  trig_addr_nxt = waddr;
                  if (POST_TRIG == 1) begin
                     state_nxt = S_READOUT;
                     cnt_nxt   = '0;
                  end else begin
                     state_nxt = S_POST;
                     cnt_nxt   = CW'(1);
                  end
               end
            end
            S_POST: begin
               cnt_nxt = cnt + 1'b1;
               if (cnt == POST_LAST) begin
                  state_nxt = S_READOUT;
                  cnt_nxt   = '0;
               end
            end
            S_READOUT: begin
               cnt_nxt = cnt + 1'b1;
               if (cnt == RD_LAST) begin
                  state_nxt = S_DONE;
                  cnt_nxt   = '0;
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         cnt         <= '0;
         waddr       <= '0;
         trig_addr   <= '0;
         triggered   <= 1'b0;
         read_enable <= 1'b0;
         done        <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         waddr       <= waddr_nxt;
         trig_addr   <= trig_addr_nxt;
         triggered   <= triggered_nxt;
         read_enable <= (state_nxt == S_READOUT);
         done        <= (state_nxt == S_DONE);
      end
   end

endmodule
